// File: rtl/hex_display_ctrl.sv
// Seven-segment display sequencer. One hex7 decoder is shared across all digits.
// A load captures a value, and the digits are then decoded one per clock, MSB first,
// into a staging frame. The whole frame is committed in a single cycle, so the
// display never shows a mix of old and new digits. Leading-zero blanking and
// decimal points are applied during the scan. Blink masking is applied live on
// the outputs.

module hex7 (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Active-low g..a segment pattern for each hex nibble
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      seg = 7'h7F;
      case (nibble)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
   end

endmodule

module hex_display_ctrl #(
   parameter int DIGITS    = 4,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   input  logic                  lz_en,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blink_en,
   output logic                  busy,
   output logic [7*DIGITS-1:0]   hex_o,
   output logic [DIGITS-1:0]     dp_o
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [6:0]    BLANK   = 7'h7F;
   localparam logic [IW-1:0] IDX_TOP = IW'(DIGITS - 1);
   localparam logic [CW-1:0] CNT_TOP = CW'(BLINK_DIV - 1);

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

   state_t            state, state_nxt;
   logic [3:0]        shadow_val [DIGITS];
   logic [DIGITS-1:0] shadow_dp;
   logic              shadow_lz;
   logic [IW-1:0]     idx;
   logic              lead;
   logic [6:0]        staging   [DIGITS];
   logic [6:0]        committed [DIGITS];
   logic [DIGITS-1:0] committed_dp;
   logic [CW-1:0]     blink_cnt;
   logic              phase;
   logic [3:0]        nibble;
   logic [6:0]        seg;
   logic              blank_digit;

   // The single shared decoder is fed by the digit currently being scanned
   assign nibble = shadow_val[idx];

   hex7 u_hex7 (
      .nibble (nibble),
      .seg    (seg)
   );

   // A zero is blanked only while still leading, never on digit 0, and never under a lit dp
   assign blank_digit = shadow_lz & lead & (nibble == 4'h0) & (idx != '0) & ~shadow_dp[idx];

   assign busy = (state != IDLE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state always uses non-blocking assignments so all registers update together.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: accept in IDLE, one digit per cycle in SCAN, single-cycle COMMIT
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load) state_nxt = SCAN;
         SCAN:    if (idx == '0) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Capture, scan into the staging frame, then commit the whole frame at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: these small register arrays are reset because the display must come up blank and an aborted frame must not survive.
         for (int k = 0; k < DIGITS; k++) begin
            shadow_val[k] <= 4'h0;
            staging[k]    <= BLANK;
            committed[k]  <= BLANK;
         end
         shadow_dp    <= '0;
         shadow_lz    <= 1'b0;
         idx          <= '0;
         lead         <= 1'b0;
         committed_dp <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  for (int k = 0; k < DIGITS; k++) shadow_val[k] <= value[4*k +: 4];
                  shadow_dp <= dp_in;
                  shadow_lz <= lz_en;
                  idx       <= IDX_TOP;
                  lead      <= 1'b1;
               end
            end
            SCAN: begin
               if (blank_digit) begin
                  staging[idx] <= BLANK;
               end else begin
                  staging[idx] <= seg;
                  lead         <= 1'b0;
               end
               if (idx != '0) idx <= idx - 1'b1;
            end
            COMMIT: begin
               for (int k = 0; k < DIGITS; k++) committed[k] <= staging[k];
               committed_dp <= shadow_dp;
            end
            default: ;
         endcase
      end
   end

   // Free-running blink timebase; the phase flips each time the counter wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == CNT_TOP) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   // Output masking: blinking digits go fully dark, including their decimal point
   always_comb begin
      hex_o = '0;
      dp_o  = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (phase && blink_en[k]) begin
            hex_o[7*k +: 7] = BLANK;
            dp_o[k]         = 1'b1;
         end else begin
            hex_o[7*k +: 7] = committed[k];
            dp_o[k]         = ~committed_dp[k];
         end
      end
   end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Sequencer that shares a single hex7 nibble-to-segment decoder across all on-board seven-segment digits. A new value is loaded through a load/busy handshake. The block walks the nibbles one per clock through the shared decoder and commits all digits atomically. It also applies leading-zero blanking, decimal points and per-digit blink. It sits between the application logic (e.g. PS/2 scan-code capture) and the HEX pins.

Parameters:
DIGITS, 4, number of seven-segment digits driven (1..8)
BLINK_DIV, 25000000, clock cycles per blink half-period (≥2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
value  input  4*DIGITS  hex value; nibble k drives digit k (digit 0 = least significant)
load  input  1  request: capture value/lz_en/dp_in when busy=0
lz_en  input  1  enable leading-zero blanking for this load
dp_in  input  DIGITS  decimal point per digit, 1 = lit
blink_en  input  DIGITS  per-digit blink enable, live (not captured)
busy  output  1  scan in progress; load ignored while high
hex_o  output  7*DIGITS  segments, digit k at [7k+6:7k], active-low, bit order 6543210 = g..a
dp_o  output  DIGITS  decimal points, active-low

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State = IDLE, busy = 0.
  - Committed segment registers = 7'h7F (all digits blank).
  - Committed dp = 0, so dp_o = all 1.
  - Blink counter = 0, blink phase = 0.
  - Staging registers undefined-safe: cleared to 7'h7F.
- FSM states: IDLE, SCAN, COMMIT.
  - IDLE:
    - load=1 captures value, lz_en and dp_in into shadow registers.
    - Sets idx = DIGITS-1 and lead = 1, sets busy = 1, then goes to SCAN.
  - SCAN (one digit per cycle, MSB first):
    - Nibble n = shadow[idx] feeds the shared hex7.
    - If lz_en & lead & n==0 & idx!=0, staging[idx] = 7'h7F; otherwise staging[idx] = decoder output and lead clears.
    - Digit 0 is never blanked, so value 0 shows "0".
    - Any lit dp on digit idx also clears lead, so the nibble is displayed.
    - When idx==0, go to COMMIT; otherwise decrement idx.
  - COMMIT:
    - Copy all staging registers and the shadow dp into the committed registers in one cycle.
    - busy = 0 on the next cycle. Return to IDLE.
- Latency:
  - load sampled at edge 0. busy is high after edge 0 for DIGITS+1 cycles.
  - New hex_o is visible after edge DIGITS+1 (5 cycles for DIGITS=4).
  - Displayed digits never show a partial update.
- Handshake:
  - load while busy=1 is ignored and not queued.
  - load held high continuously reloads each time IDLE is re-entered, i.e. every DIGITS+2 cycles.
  - Inputs are sampled only at the accepting edge and may change afterwards.
- Blink:
  - Free-running counter counts 0..BLINK_DIV-1. At wrap, phase toggles.
  - Counter runs independently of the FSM and is not reset by load.
  - hex_o[k] = (phase & blink_en[k]) ? 7'h7F : committed[k]. dp_o[k] is forced to 1 under the same condition.
  - Output masking is combinational from registered phase and committed data, so it is glitch-free per edge.
- Reset mid-scan: immediate abort. Outputs go blank (7'h7F) and busy goes to 0. A partially built staging frame is never committed.
- Decoder mapping is that of hex7, active-low, e.g.:
  - 0 → 7'h40, 1 → 7'h79, 2 → 7'h24, 3 → 7'h30, 4 → 7'h19
  - 7 → 7'h78, A → 7'h08, F → 7'h0E
- Exactly one hex7 instance; no per-digit decoders.

Test Plan:
- Reset then no load → hex_o all 7'h7F, dp_o=4'hF, busy=0. Assert rst_n mid-blink → counter and phase return to 0.
- load value=16'h1234, lz_en=0, dp_in=0:
  - busy high for exactly 5 cycles.
  - hex_o unchanged until edge 5, then digits3..0 = 7'h79, 7'h24, 7'h30, 7'h19.
- Leading-zero blanking:
  - value=16'h0070, lz_en=1 → digits3..0 = 7'h7F, 7'h7F, 7'h78, 7'h40.
  - value=16'h0000, lz_en=1 → 7'h7F ×3, then digit0 = 7'h40.
  - value=16'h00AF, lz_en=1, dp_in=4'b0100 → digit2 shows 7'h40 with dp_o[2]=0.
- Load collision: load 16'hFFFF, then pulse load with 16'h1111 two cycles later (busy=1) → display ends 7'h0E ×4; second load is lost, busy falls once.
- Blink, with BLINK_DIV=4 in the bench and blink_en=4'b0001 after 16'h1234 is displayed:
  - digit0 alternates 7'h19 / 7'h7F every 4 cycles.
  - digits 1-3 remain steady.
- Reset mid-scan: assert rst_n low at cycle 2 of a scan → outputs 7'h7F, busy=0 immediately. After release, a new load of 16'hA000 completes normally (digit3 = 7'h08).
